// File: rtl/reg_file.sv
// reg_file: 32-entry integer register file for the single-cycle RISC-V core.
// Two combinational read ports with write-first bypass, one write port, and a
// valid/ready debug dump port that streams every register in index order.
//
// Dump handshake: dump_valid_o is high for the whole SCAN state and the beat
// (dump_idx_o, dump_data_o) is stable in index while dump_ready_i is low; a
// beat transfers on a rising edge where dump_valid_o && dump_ready_i. Data
// follows the live register contents, including a same-cycle write.
module reg_file #(
   parameter int  DataWidth = 32,
   parameter int  NumRegs   = 32,
   localparam int AddrWidth = $clog2(NumRegs)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] rs1_addr_i,
   input  logic [AddrWidth-1:0] rs2_addr_i,
   output logic [DataWidth-1:0] rs1_data_o,
   output logic [DataWidth-1:0] rs2_data_o,
   input  logic                 rd_we_i,
   input  logic [AddrWidth-1:0] rd_addr_i,
   input  logic [DataWidth-1:0] rd_data_i,
   input  logic                 dump_req_i,
   output logic                 dump_valid_o,
   input  logic                 dump_ready_i,
   output logic [AddrWidth-1:0] dump_idx_o,
   output logic [DataWidth-1:0] dump_data_o,
   output logic                 dump_busy_o,
   output logic [1:0]           dump_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } dump_state_e;

   logic [DataWidth-1:0] regs_q [NumRegs];
   dump_state_e          state_q;
   logic [AddrWidth-1:0] cnt_q;
   logic                 valid_q;
   logic                 busy_q;
   logic                 wr_en;
   logic                 xfer;

   // x0 is hardwired, so a write aimed at it is dropped here
   assign wr_en = rd_we_i && (rd_addr_i != '0);
   assign xfer  = valid_q && dump_ready_i;

   // Write-first read: a same-cycle write to the addressed register wins
   function automatic logic [DataWidth-1:0] bypass_read(input logic [AddrWidth-1:0] addr);
      logic [DataWidth-1:0] val;
      val = '0;
      if (wr_en && (addr == rd_addr_i)) begin
         val = rd_data_i;
      end else if (addr != '0) begin
         val = regs_q[addr];
      end
      return val;
   endfunction

   // Architectural register storage; entry 0 is never written and stays 0
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[rd_addr_i] <= rd_data_i;
      end
   end

   // Dump FSM: walk indices 0..NumRegs-1, one beat per accepted handshake
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dump_req_i) begin
                  state_q <= SCAN;
                  cnt_q   <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            SCAN: begin
               if (xfer) begin
                  // Counter wraps to 0 on the last beat, which is never shown
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == AddrWidth'(NumRegs - 1)) begin
                     state_q <= DONE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Output drive: core reads are never blocked by a dump in progress
   always_comb begin
      rs1_data_o   = bypass_read(rs1_addr_i);
      rs2_data_o   = bypass_read(rs2_addr_i);
      dump_valid_o = valid_q;
      dump_busy_o  = busy_q;
      dump_idx_o   = cnt_q;
      dump_data_o  = valid_q ? bypass_read(cnt_q) : '0;
      dump_state_o = state_q;
   end

endmodule
